// File: rtl/picoblaze_uart_tx.sv
// Port-mapped 8N1 UART transmitter for the Picoblaze I/O bus: data writes are
// queued in a circular FIFO and serialised on TX_OUT; a status byte is readable for polling.
module picoblaze_uart_tx #(
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          BAUD        = 115200,
    parameter logic [7:0]  DATA_PORT   = 8'h01,
    parameter logic [7:0]  STATUS_PORT = 8'h02,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       WRITE_STROBE,
    input  logic       READ_STROBE,
    output logic [7:0] IN_PORT,
    output logic       TX_OUT,
    output logic       TX_BUSY
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             overflow_reg;
    logic             pending_reg;
    logic             busy_reg;
    logic [7:0]       in_port_reg, in_port_next;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             pop;

    logic             full, empty_now, wr_data, push, ovf_set, ovf_clr, baud_done;
    logic [3:0]       cnt_sat;
    logic             unused_read_strobe;

    // The status read is side-effect free, so the read qualifier is not needed.
    assign unused_read_strobe = READ_STROBE;

    assign full      = (count_reg == DEPTH_C);
    assign empty_now = (count_reg == '0);
    assign wr_data   = WRITE_STROBE && (PORT_ID == DATA_PORT);
    assign push      = wr_data && !full;
    assign ovf_set   = wr_data && full;
    assign ovf_clr   = WRITE_STROBE && (PORT_ID == STATUS_PORT) && OUT_PORT[0];
    assign baud_done = (baud_reg == BAUD_LAST);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        cnt_sat = 4'(count_reg);
        if (int'(count_reg) > 15) begin
            cnt_sat = 4'hF;
        end
        in_port_next = 8'h00;
        if (PORT_ID == STATUS_PORT) begin
            in_port_next = {cnt_sat, overflow_reg, busy_reg, full, empty_now};
        end
    end

    // The FSM looks at a registered copy of "FIFO has data", which sets the
    // two-edge write-to-start-bit latency and keeps the pop path short.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (pending_reg) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    state_next = START;
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    baud_next    = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + BAUD_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (push) begin
            mem[wr_ptr_reg] <= OUT_PORT;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            pending_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            in_port_reg  <= 8'h00;
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            tx_reg       <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
            pending_reg  <= !empty_now;
            busy_reg     <= (state_next != IDLE) || (count_next != '0);
            in_port_reg  <= in_port_next;
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
        end
    end

    assign IN_PORT = in_port_reg;
    assign TX_OUT  = tx_reg;
    assign TX_BUSY = busy_reg;

endmodule

// File: tb/tb_picoblaze_uart_tx.sv
// Bench for picoblaze_uart_tx at DIV=10: register-decode vectors from a table, plus
// hand-written frame timing, overflow, clear and mid-frame reset sequences.
module tb_picoblaze_uart_tx;

    logic       clk = 1'b0;
    logic       RESET_IN = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       WRITE_STROBE = 1'b0;
    logic       READ_STROBE = 1'b0;
    logic [7:0] IN_PORT;
    logic       TX_OUT;
    logic       TX_BUSY;

    int n_run = 0;
    int n_fail = 0;

    // Decoded frames: {start_was_low, stop_was_high, data}
    logic [9:0] rx_q [$];

    picoblaze_uart_tx #(
        .CLK_HZ(100), .BAUD(10), .DATA_PORT(8'h01), .STATUS_PORT(8'h02), .FIFO_DEPTH(16)
    ) dut (
        .CLK_IN(clk), .RESET_IN(RESET_IN), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .WRITE_STROBE(WRITE_STROBE), .READ_STROBE(READ_STROBE),
        .IN_PORT(IN_PORT), .TX_OUT(TX_OUT), .TX_BUSY(TX_BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] port_id;
        logic [7:0] data;
        logic       wr;
        logic       rd;
        logic [7:0] exp_in;
        string      name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        PORT_ID = p;
        OUT_PORT = d;
        WRITE_STROBE = 1'b1;
        @(posedge clk);
        #1;
        WRITE_STROBE = 1'b0;
        PORT_ID = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic rd_status(input string name, input logic [7:0] exp);
        PORT_ID = 8'h02;
        READ_STROBE = 1'b1;
        tick(1);
        READ_STROBE = 1'b0;
        PORT_ID = 8'h00;
        chk(name, 32'(IN_PORT), 32'(exp));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (TX_BUSY !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_within_budget", 32'(n < budget), 32'd1);
        tick(3);
    endtask

    task automatic chk_rx(input string name, input logic [7:0] exp);
        logic [9:0] got = 10'hxxx;
        if (rx_q.size() != 0) got = rx_q.pop_front();
        chk(name, 32'(got), 32'({2'b11, exp}));
    endtask

    task automatic quiet_line(input string name, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (TX_OUT !== 1'b1) lows++;
        end
        chk(name, 32'(lows), 32'd0);
    endtask

    // Frame monitor: samples mid-bit after each falling edge of the line
    initial begin
        logic       prev;
        logic       start_low;
        logic       stop_bit;
        logic [7:0] b;
        prev = 1'b1;
        b = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (prev && TX_OUT === 1'b0) begin
                repeat (5) @(posedge clk);
                #2;
                start_low = (TX_OUT === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(posedge clk);
                    #2;
                    b[i] = TX_OUT;
                end
                repeat (10) @(posedge clk);
                #2;
                stop_bit = (TX_OUT === 1'b1);
                rx_q.push_back({start_low, stop_bit, b});
            end
            prev = TX_OUT;
        end
    end

    initial begin
        vecs[0] = '{8'h02, 8'h00, 1'b0, 1'b1, 8'h01, "status_read_idle"};
        vecs[1] = '{8'h07, 8'hFF, 1'b1, 1'b0, 8'h00, "write_port07"};
        vecs[2] = '{8'h07, 8'h00, 1'b0, 1'b1, 8'h00, "read_port07"};
        vecs[3] = '{8'h02, 8'h00, 1'b0, 1'b0, 8'h01, "status_no_strobe"};
        vecs[4] = '{8'h02, 8'hFE, 1'b1, 1'b0, 8'h01, "ctrl_write_bit0_zero"};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, "read_port00"};
        vecs[6] = '{8'h03, 8'hFF, 1'b1, 1'b0, 8'h00, "write_port03"};
        vecs[7] = '{8'h02, 8'h01, 1'b1, 1'b0, 8'h01, "ctrl_clear_no_ovf"};
        vecs[8] = '{8'h02, 8'h00, 1'b0, 1'b1, 8'h01, "status_still_empty"};

        // Reset state
        RESET_IN = 1'b1;
        tick(3);
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_in_port", 32'(IN_PORT), 32'd0);
        chk("reset_busy", 32'(TX_BUSY), 32'd0);
        RESET_IN = 1'b0;
        tick(1);

        // Register decode vectors; none of these may start a frame
        for (int i = 0; i < 9; i++) begin
            PORT_ID = vecs[i].port_id;
            OUT_PORT = vecs[i].data;
            WRITE_STROBE = vecs[i].wr;
            READ_STROBE = vecs[i].rd;
            tick(1);
            WRITE_STROBE = 1'b0;
            READ_STROBE = 1'b0;
            PORT_ID = 8'h00;
            OUT_PORT = 8'h00;
            chk(vecs[i].name, 32'(IN_PORT), 32'(vecs[i].exp_in));
            chk({vecs[i].name, "_busy"}, 32'(TX_BUSY), 32'd0);
        end
        quiet_line("no_frame_after_decode", 30);
        chk("no_bytes_after_decode", 32'(rx_q.size()), 32'd0);

        // Single byte 0x55: start bit two edges after the write, busy for the frame
        wr(8'h01, 8'h55);
        chk("t1_tx_after_write", 32'(TX_OUT), 32'd1);
        chk("t1_busy_after_write", 32'(TX_BUSY), 32'd1);
        tick(1);
        chk("t1_tx_edge_n1", 32'(TX_OUT), 32'd1);
        tick(1);
        chk("t1_tx_edge_n2", 32'(TX_OUT), 32'd0);
        tick(99);
        chk("t1_busy_before_end", 32'(TX_BUSY), 32'd1);
        tick(1);
        chk("t1_busy_at_end", 32'(TX_BUSY), 32'd0);
        chk("t1_tx_at_end", 32'(TX_OUT), 32'd1);
        tick(2);
        chk_rx("t1_byte_55", 8'h55);

        // Back-to-back bytes: one extra idle-high clock between frames
        wr(8'h01, 8'hA3);
        wr(8'h01, 8'h0F);
        tick(1);
        chk("t2_first_start", 32'(TX_OUT), 32'd0);
        tick(100);
        chk("t2_gap_high", 32'(TX_OUT), 32'd1);
        tick(1);
        chk("t2_second_start", 32'(TX_OUT), 32'd0);
        wait_idle(300);
        chk_rx("t2_byte_A3", 8'hA3);
        chk_rx("t2_byte_0F", 8'h0F);

        // Overflow: 20 pushes, 17 survive (1 in flight + 16 queued)
        for (int i = 0; i < 20; i++) wr(8'h01, 8'(i));
        rd_status("t3_status_full", 8'hFE);
        wait_idle(2000);
        chk("t3_frame_count", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 17; i++) chk_rx($sformatf("t3_byte_%02h", i), 8'(i));

        // Sticky overflow: reads keep it, control write clears it
        rd_status("t4_status_ovf", 8'h09);
        rd_status("t4_status_ovf_reread", 8'h09);
        wr(8'h02, 8'h01);
        chk("t4_status_clear_edge", 32'(IN_PORT), 32'h09);
        rd_status("t4_status_cleared", 8'h01);

        // Reset in the middle of the data bits, with a second byte still queued
        wr(8'h01, 8'h00);
        wr(8'h01, 8'h00);
        tick(41);
        chk("t5_mid_data_low", 32'(TX_OUT), 32'd0);
        RESET_IN = 1'b1;
        tick(1);
        RESET_IN = 1'b0;
        chk("t5_tx_after_reset", 32'(TX_OUT), 32'd1);
        chk("t5_busy_after_reset", 32'(TX_BUSY), 32'd0);
        chk("t5_in_port_after_reset", 32'(IN_PORT), 32'd0);
        rd_status("t5_status_after_reset", 8'h01);
        tick(150);
        rx_q.delete();
        quiet_line("t5_no_further_frame", 300);
        chk("t5_no_bytes", 32'(rx_q.size()), 32'd0);
        chk("t5_busy_final", 32'(TX_BUSY), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
